// File: rtl/moore_seq_ctrl.sv
// Word-to-bit sequencer feeding a programmable overlapping Moore pattern detector.
// Reports per-word match counts on a valid/ready port and keeps a saturating total.
module moore_seq_ctrl #(
  parameter int W        = 8,
  parameter int PLEN_MAX = 8,
  parameter int CNT_W    = 8,
  localparam int LW = $clog2(PLEN_MAX + 1),
  localparam int OW = $clog2(W + 1),
  localparam int IW = $clog2(W)
) (
  input  logic                clk,
  input  logic                nres,
  input  logic                cfg_we,
  input  logic [PLEN_MAX-1:0] cfg_pat,
  input  logic [LW-1:0]       cfg_len,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [W-1:0]        in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OW-1:0]       out_cnt,
  output logic [CNT_W-1:0]    total_cnt,
  output logic                match,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        data_q, data_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [OW-1:0]       wcnt_q, wcnt_d;
  logic [PLEN_MAX-1:0] hist_q, hist_d;
  logic [LW-1:0]       hcnt_q, hcnt_d;
  logic [PLEN_MAX-1:0] pat_q, pat_d;
  logic [LW-1:0]       len_q, len_d;
  logic                match_q, match_d;
  logic [CNT_W-1:0]    total_q, total_d;

  logic                cur_bit;
  logic [PLEN_MAX-1:0] shift_hist;
  logic [LW-1:0]       shift_cnt;
  logic [PLEN_MAX-1:0] mask;
  logic                hit;
  logic                cfg_ok;

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      hist_q  <= '0;
      hcnt_q  <= '0;
      pat_q   <= PLEN_MAX'(5'b00010);
      len_q   <= LW'(5);
      match_q <= 1'b0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      hist_q  <= hist_d;
      hcnt_q  <= hcnt_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      match_q <= match_d;
      total_q <= total_d;
    end
  end

  // The match is judged on the history as it will look after this bit is shifted in.
  always_comb begin
    cur_bit    = data_q[idx_q];
    shift_hist = {hist_q[PLEN_MAX-2:0], cur_bit};
    shift_cnt  = (hcnt_q == LW'(PLEN_MAX)) ? hcnt_q : hcnt_q + LW'(1);
    mask       = '0;
    for (int i = 0; i < PLEN_MAX; i++) begin
      mask[i] = (i < int'(len_q));
    end
    hit    = (shift_cnt >= len_q) && ((shift_hist & mask) == (pat_q & mask));
    cfg_ok = cfg_we && (state_q == IDLE) && (cfg_len != '0) && (cfg_len <= LW'(PLEN_MAX));
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    hist_d    = hist_q;
    hcnt_d    = hcnt_q;
    pat_d     = pat_q;
    len_d     = len_q;
    match_d   = 1'b0;
    total_d   = total_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          idx_d   = IW'(W - 1);
          wcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        hist_d = shift_hist;
        hcnt_d = shift_cnt;
        if (hit) begin
          wcnt_d  = wcnt_q + OW'(1);
          match_d = 1'b1;
          if (total_q != '1) begin
            total_d = total_q + CNT_W'(1);
          end
        end
        idx_d = idx_q - IW'(1);
        if (idx_q == '0) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new pattern invalidates whatever history was collected against the old one.
    if (cfg_ok) begin
      pat_d  = cfg_pat;
      len_d  = cfg_len;
      hist_d = '0;
      hcnt_d = '0;
    end

    if (clear) begin
      hist_d  = '0;
      hcnt_d  = '0;
      total_d = '0;
    end
  end

  assign out_cnt   = wcnt_q;
  assign total_cnt = total_q;
  assign match     = match_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Directed self-checking bench for moore_seq_ctrl; a second instance with a
// 2-bit total counter shares the stimulus to exercise saturation.
module tb_moore_seq_ctrl;

  logic       clk;
  logic       nres;
  logic       cfgWe;
  logic [7:0] cfgPat;
  logic [3:0] cfgLen;
  logic       clear;
  logic       inValid;
  logic [7:0] inData;
  logic       outReady;

  logic       inReady, outValid, match, busy;
  logic [3:0] outCnt;
  logic [7:0] totalCnt;

  logic       inReadyS, outValidS, matchS, busyS;
  logic [3:0] outCntS;
  logic [1:0] totalCntS;

  int compared   = 0;
  int mismatched = 0;

  logic [8:1] mTrace;
  logic [8:1] vTrace;

  moore_seq_ctrl #(.W(8), .PLEN_MAX(8), .CNT_W(8)) u_dut (
    .clk(clk), .nres(nres), .cfg_we(cfgWe), .cfg_pat(cfgPat), .cfg_len(cfgLen),
    .clear(clear), .in_valid(inValid), .in_data(inData), .in_ready(inReady),
    .out_valid(outValid), .out_ready(outReady), .out_cnt(outCnt),
    .total_cnt(totalCnt), .match(match), .busy(busy)
  );

  moore_seq_ctrl #(.W(8), .PLEN_MAX(8), .CNT_W(2)) u_sat (
    .clk(clk), .nres(nres), .cfg_we(cfgWe), .cfg_pat(cfgPat), .cfg_len(cfgLen),
    .clear(clear), .in_valid(inValid), .in_data(inData), .in_ready(inReadyS),
    .out_valid(outValidS), .out_ready(outReady), .out_cnt(outCntS),
    .total_cnt(totalCntS), .match(matchS), .busy(busyS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word for a single edge; it is accepted at that edge when idle.
  task automatic applyStimulus(input logic [7:0] word);
    inValid = 1'b1;
    inData  = word;
    tick();
    inValid = 1'b0;
  endtask

  // Step through the eight shift edges, recording match and out_valid after each.
  task automatic shiftWord();
    for (int k = 1; k <= 8; k++) begin
      tick();
      mTrace[k] = match;
      vTrace[k] = outValid;
    end
  endtask

  initial begin
    nres = 1'b0; cfgWe = 1'b0; cfgPat = '0; cfgLen = '0; clear = 1'b0;
    inValid = 1'b0; inData = '0; outReady = 1'b1;
    repeat (2) tick();

    checkOutput("rst in_ready", 32'(inReady), 1);
    checkOutput("rst busy", 32'(busy), 0);
    checkOutput("rst out_valid", 32'(outValid), 0);
    checkOutput("rst out_cnt", 32'(outCnt), 0);
    checkOutput("rst total", 32'(totalCnt), 0);
    checkOutput("rst match", 32'(match), 0);
    checkOutput("rst busyS", 32'(busyS), 0);
    nres = 1'b1;
    tick();

    $display("[TB] default pattern, word 00010001");
    applyStimulus(8'b00010001);
    checkOutput("s1 busy", 32'(busy), 1);
    checkOutput("s1 in_ready", 32'(inReady), 0);
    shiftWord();
    checkOutput("s1 match trace", 32'(mTrace), 32'b00010000);
    checkOutput("s1 valid trace", 32'(vTrace), 32'b10000000);
    checkOutput("s1 out_cnt", 32'(outCnt), 1);
    checkOutput("s1 total", 32'(totalCnt), 1);
    checkOutput("s1 totalS", 32'(totalCntS), 1);
    tick();
    checkOutput("s1 idle out_valid", 32'(outValid), 0);
    checkOutput("s1 idle in_ready", 32'(inReady), 1);
    checkOutput("s1 idle busy", 32'(busy), 0);

    $display("[TB] history carry across words");
    applyStimulus(8'h00);
    shiftWord();
    checkOutput("s2 match trace", 32'(mTrace), 32'b00000001);
    checkOutput("s2 out_cnt", 32'(outCnt), 1);
    checkOutput("s2 total", 32'(totalCnt), 2);
    checkOutput("s2 totalS", 32'(totalCntS), 2);
    tick();

    $display("[TB] clear, load 010/3 with word accept, overlap");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clr total", 32'(totalCnt), 0);
    checkOutput("clr totalS", 32'(totalCntS), 0);
    checkOutput("clr out_cnt kept", 32'(outCnt), 1);
    outReady = 1'b0;
    cfgWe = 1'b1; cfgPat = 8'b010; cfgLen = 4'd3;
    applyStimulus(8'b01010101);
    cfgWe = 1'b0;
    shiftWord();
    checkOutput("s3 match trace", 32'(mTrace), 32'b01010100);
    checkOutput("s3 out_cnt", 32'(outCnt), 3);
    checkOutput("s3 total", 32'(totalCnt), 3);
    checkOutput("s3 totalS", 32'(totalCntS), 3);

    $display("[TB] back-pressure with pending word");
    inValid = 1'b1;
    inData  = 8'b01000000;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("bp out_valid", 32'(outValid), 1);
      checkOutput("bp out_cnt", 32'(outCnt), 3);
      checkOutput("bp in_ready", 32'(inReady), 0);
      checkOutput("bp total", 32'(totalCnt), 3);
    end
    outReady = 1'b1;
    tick();
    checkOutput("bp release out_valid", 32'(outValid), 0);
    checkOutput("bp release in_ready", 32'(inReady), 1);
    checkOutput("bp release busy", 32'(busy), 0);

    $display("[TB] cfg_we during SHIFT ignored");
    applyStimulus(8'b01000000);
    cfgWe = 1'b1; cfgPat = 8'b111; cfgLen = 4'd3;
    shiftWord();
    cfgWe = 1'b0;
    checkOutput("s4 match trace", 32'(mTrace), 32'b00000101);
    checkOutput("s4 out_cnt", 32'(outCnt), 2);
    checkOutput("s4 total", 32'(totalCnt), 5);
    checkOutput("s4 totalS sat", 32'(totalCntS), 3);
    tick();

    $display("[TB] illegal lengths in IDLE ignored");
    cfgWe = 1'b1; cfgPat = 8'hFF; cfgLen = 4'd0;
    tick();
    cfgPat = 8'h00; cfgLen = 4'd9;
    tick();
    cfgWe = 1'b0;
    applyStimulus(8'b10100000);
    shiftWord();
    checkOutput("s5 match trace", 32'(mTrace), 32'b00001010);
    checkOutput("s5 out_cnt", 32'(outCnt), 2);
    checkOutput("s5 total", 32'(totalCnt), 7);
    checkOutput("s5 totalS sat", 32'(totalCntS), 3);
    tick();

    $display("[TB] async reset mid-word");
    applyStimulus(8'hFF);
    repeat (3) tick();
    #2 nres = 1'b0;
    #1;
    checkOutput("ar busy", 32'(busy), 0);
    checkOutput("ar in_ready", 32'(inReady), 1);
    checkOutput("ar out_valid", 32'(outValid), 0);
    checkOutput("ar out_cnt", 32'(outCnt), 0);
    checkOutput("ar total", 32'(totalCnt), 0);
    checkOutput("ar totalS", 32'(totalCntS), 0);
    checkOutput("ar match", 32'(match), 0);
    tick();
    nres = 1'b1;
    tick();
    checkOutput("ar no report", 32'(outValid), 0);

    applyStimulus(8'b00010001);
    shiftWord();
    checkOutput("s6 match trace", 32'(mTrace), 32'b00010000);
    checkOutput("s6 valid trace", 32'(vTrace), 32'b10000000);
    checkOutput("s6 out_cnt", 32'(outCnt), 1);
    checkOutput("s6 total", 32'(totalCnt), 1);
    tick();

    $display("[TB] clear coinciding with a match");
    applyStimulus(8'b00010001);
    for (int k = 1; k <= 8; k++) begin
      clear = (k == 5);
      tick();
    end
    clear = 1'b0;
    checkOutput("s7 out_cnt", 32'(outCnt), 2);
    checkOutput("s7 total", 32'(totalCnt), 0);
    checkOutput("s7 totalS", 32'(totalCntS), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
